nvmain_cmd_issuer: RTL and testbench



---
 rtl/nvmain_cmd_pkg.sv | 62 ++++++
 rtl/nvmain_req_fifo.sv | 56 +++++
 rtl/nvmain_cmd_issuer.sv | 200 ++++++++++++++++++++
 tb/tb_nvmain_cmd_issuer.sv | 483 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nvmain_cmd_pkg.sv
// Shared types and opcode table for the NVMain command issuer.
// Request opcodes, the buffered request record, FSM states and the
// lowercase (query) / uppercase (issue) command characters.
package nvmain_cmd_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_LOAD  = 2'd2,
    OP_CTRL  = 2'd3
  } op_e;

  // Query (lowercase) command characters
  localparam logic [7:0] Q_READ  = 8'h72;
  localparam logic [7:0] Q_WRITE = 8'h77;
  localparam logic [7:0] Q_LOAD  = 8'h6C;
  localparam logic [7:0] Q_CTRL  = 8'h63;

  // Issue (uppercase) command characters
  localparam logic [7:0] I_READ  = 8'h52;
  localparam logic [7:0] I_WRITE = 8'h57;
  localparam logic [7:0] I_LOAD  = 8'h4C;
  localparam logic [7:0] I_CTRL  = 8'h43;

  typedef struct packed {
    op_e         op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] tag;
    logic [7:0]  tid;
  } req_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_QUERY,
    ST_WAIT,
    ST_ISSUE,
    ST_BACKOFF,
    ST_COOL
  } state_e;

  function automatic logic [7:0] query_code(input op_e op);
    query_code = Q_READ;
    case (op)
      OP_READ:  query_code = Q_READ;
      OP_WRITE: query_code = Q_WRITE;
      OP_LOAD:  query_code = Q_LOAD;
      OP_CTRL:  query_code = Q_CTRL;
    endcase
  endfunction

  function automatic logic [7:0] issue_code(input op_e op);
    issue_code = I_READ;
    case (op)
      OP_READ:  issue_code = I_READ;
      OP_WRITE: issue_code = I_WRITE;
      OP_LOAD:  issue_code = I_LOAD;
      OP_CTRL:  issue_code = I_CTRL;
    endcase
  endfunction

endpackage

// File: rtl/nvmain_req_fifo.sv
// Synchronous request FIFO with first-word fall-through read data.
// DEPTH must be a power of two so the pointers wrap naturally.
// Caller guarantees push only when !full (or popping) and pop only when !empty.
module nvmain_req_fifo
  import nvmain_cmd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  req_t wr_data,
  output req_t rd_data,
  output logic full,
  output logic empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  req_t           mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;

  // Pointer and occupancy bookkeeping.
  // NOTE: state is updated with <= so every register samples pre-edge values;
  // blocking assignments here would make results depend on statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write port.
  // NOTE: the array is deliberately not reset; the count gates visibility, and
  // leaving it out of reset lets it map onto plain RAM/register-file cells.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/nvmain_cmd_issuer.sv
// NVMain command issuer: buffers requests and runs the query/issue handshake
// toward the VPI command sink, retrying with backoff while not issuable.
// Optional build macro NVMAIN_ISSUER_STATS_EN adds saturating
// issued/retry/drop statistics counters as extra outputs.
module nvmain_cmd_issuer
  import nvmain_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int QUERY_WAIT = 3,
  parameter int RETRY_GAP  = 4,
  parameter int MAX_RETRY  = 15,
  parameter int COOLDOWN   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [31:0] req_tag,
  input  logic [7:0]  req_tid,
  output logic        command_enable,
  output logic [7:0]  arg0,
  output logic [31:0] arg1,
  output logic [31:0] arg2,
  output logic [31:0] arg3,
  output logic [7:0]  arg4,
  input  logic        is_issuable,
  output logic        issue_done,
  output logic        drop_err,
  output logic        busy
`ifdef NVMAIN_ISSUER_STATS_EN
  ,
  output logic [31:0] stat_issued,
  output logic [31:0] stat_retries,
  output logic [15:0] stat_drops
`endif
);

  localparam int TW = 16;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [TW-1:0] retry_q, retry_d;
  op_e           op_q;

  req_t in_req;
  req_t head;
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic sample;
  logic sample_ok;
  logic sample_fail;
  logic drop;

  assign in_req = '{op: op_e'(req_op), addr: req_addr, data: req_data,
                    tag: req_tag, tid: req_tid};

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign pop       = (state_q == ST_IDLE) && !fifo_empty;
  assign req_ready = !fifo_full || pop;
  assign push      = req_valid && req_ready;

  nvmain_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data (in_req),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // is_issuable only matters on the last WAIT cycle.
  assign sample      = (state_q == ST_WAIT) && (timer_q == '0);
  assign sample_ok   = sample && is_issuable;
  assign sample_fail = sample && !is_issuable;
  assign drop        = sample_fail && (MAX_RETRY != 0) && (retry_q == TW'(MAX_RETRY));

  // State, phase timer and retry counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
    end
  end

  // Next-state logic for the query/wait/issue/backoff/cooldown sequence.
  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    case (state_q)
      ST_IDLE: begin
        retry_d = '0;
        if (pop) state_d = ST_QUERY;
      end
      ST_QUERY: begin
        state_d = ST_WAIT;
        timer_d = TW'(QUERY_WAIT - 1);
      end
      ST_WAIT: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else if (is_issuable) begin
          state_d = ST_ISSUE;
        end else if (drop) begin
          state_d = ST_IDLE;
        end else begin
          retry_d = retry_q + 1'b1;
          if (RETRY_GAP == 0) begin
            state_d = ST_QUERY;
          end else begin
            state_d = ST_BACKOFF;
            timer_d = TW'(RETRY_GAP - 1);
          end
        end
      end
      ST_BACKOFF: begin
        if (timer_q == '0) state_d = ST_QUERY;
        else               timer_d = timer_q - 1'b1;
      end
      ST_ISSUE: begin
        if (COOLDOWN == 0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_COOL;
          timer_d = TW'(COOLDOWN - 1);
        end
      end
      ST_COOL: begin
        if (timer_q == '0) begin
          state_d = ST_IDLE;
          retry_d = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Command argument bus: loaded at pop, arg0 flips to uppercase on a good sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q <= OP_READ;
      arg0 <= '0;
      arg1 <= '0;
      arg2 <= '0;
      arg3 <= '0;
      arg4 <= '0;
    end else if (pop) begin
      op_q <= head.op;
      arg0 <= query_code(head.op);
      arg1 <= head.addr;
      arg2 <= head.data;
      arg3 <= head.tag;
      arg4 <= head.tid;
    end else if (sample_ok) begin
      arg0 <= issue_code(op_q);
    end
  end

  // Drop indication is registered so it pulses on the first IDLE cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) drop_err <= 1'b0;
    else        drop_err <= drop;
  end

  assign command_enable = (state_q == ST_QUERY) || (state_q == ST_ISSUE);
  assign issue_done     = (state_q == ST_ISSUE);
  assign busy           = (state_q != ST_IDLE) || !fifo_empty;

`ifdef NVMAIN_ISSUER_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_issued  <= '0;
      stat_retries <= '0;
      stat_drops   <= '0;
    end else begin
      if (issue_done && (stat_issued != '1))             stat_issued  <= stat_issued + 1'b1;
      if (sample_fail && !drop && (stat_retries != '1))  stat_retries <= stat_retries + 1'b1;
      if (drop && (stat_drops != '1))                    stat_drops   <= stat_drops + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_nvmain_cmd_issuer.sv
// Self-checking bench for nvmain_cmd_issuer. A transaction-level schedule is
// computed from the handshake timing rules and compared against every observed
// command strobe, issue_done and drop_err. A sink process answers each query
// sample from a per-request failure plan and drives noise elsewhere.
module tb_nvmain_cmd_issuer;

  localparam int DEPTH = 4;
  localparam int QW    = 3;
  localparam int RG    = 4;
  localparam int MR    = 2;
  localparam int CD    = 2;
  localparam int PER   = QW + RG + 1;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [31:0] req_tag;
  logic [7:0]  req_tid;
  logic        command_enable;
  logic [7:0]  arg0;
  logic [31:0] arg1;
  logic [31:0] arg2;
  logic [31:0] arg3;
  logic [7:0]  arg4;
  logic        is_issuable;
  logic        issue_done;
  logic        drop_err;
  logic        busy;
`ifdef NVMAIN_ISSUER_STATS_EN
  logic [31:0] stat_issued;
  logic [31:0] stat_retries;
  logic [15:0] stat_drops;
`endif

  nvmain_cmd_issuer #(
    .FIFO_DEPTH (DEPTH),
    .QUERY_WAIT (QW),
    .RETRY_GAP  (RG),
    .MAX_RETRY  (MR),
    .COOLDOWN   (CD)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .req_tag        (req_tag),
    .req_tid        (req_tid),
    .command_enable (command_enable),
    .arg0           (arg0),
    .arg1           (arg1),
    .arg2           (arg2),
    .arg3           (arg3),
    .arg4           (arg4),
    .is_issuable    (is_issuable),
    .issue_done     (issue_done),
    .drop_err       (drop_err),
    .busy           (busy)
`ifdef NVMAIN_ISSUER_STATS_EN
    ,
    .stat_issued    (stat_issued),
    .stat_retries   (stat_retries),
    .stat_drops     (stat_drops)
`endif
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] tag;
    logic [7:0]  tid;
    int          fails;
  } treq_t;

  typedef struct {
    int          cyc;
    logic [7:0]  a0;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [31:0] a3;
    logic [7:0]  a4;
  } cmd_t;

  treq_t reqs[$];
  cmd_t  cmd_log[$];
  cmd_t  exp_cmd[$];
  int    done_log[$];
  int    exp_done[$];
  int    drop_log[$];
  int    exp_drop[$];
  int    pop_at[$];
  int    end_cyc;

  int   tests_run = 0;
  int   failed    = 0;
  int   cyc       = 0;
  int   req_idx   = 0;
  int   q_in_req  = 0;
  int   since_q   = 100;
  int   ce_violations = 0;
  logic prev_ce   = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Query character per request op: read 'r', write 'w', load 'l', control 'c'.
  function automatic logic [7:0] qchar(input logic [1:0] op);
    case (op)
      2'd0:    qchar = 8'h72;
      2'd1:    qchar = 8'h77;
      2'd2:    qchar = 8'h6C;
      default: qchar = 8'h63;
    endcase
  endfunction

  function automatic cmd_t mk_cmd(input int c, input logic [7:0] a0, input treq_t r);
    cmd_t m;
    m.cyc = c;
    m.a0  = a0;
    m.a1  = r.addr;
    m.a2  = r.data;
    m.a3  = r.tag;
    m.a4  = r.tid;
    return m;
  endfunction

  // Monitor plus sink: logs bus events and answers query samples from the plan.
  initial begin
    cmd_t c;
    is_issuable = 1'b0;
    forever begin
      @(negedge clk);
      if (command_enable && prev_ce) ce_violations++;
      prev_ce = command_enable;
      if (issue_done) begin
        done_log.push_back(cyc);
        req_idx++;
        q_in_req = 0;
      end
      if (drop_err) begin
        drop_log.push_back(cyc);
        req_idx++;
        q_in_req = 0;
      end
      if (command_enable) begin
        c.cyc = cyc; c.a0 = arg0; c.a1 = arg1; c.a2 = arg2; c.a3 = arg3; c.a4 = arg4;
        cmd_log.push_back(c);
        if (arg0 >= 8'h61) begin
          q_in_req++;
          since_q = 0;
        end else begin
          since_q = 100;
        end
      end else if (since_q < 100) begin
        since_q++;
      end
      if (since_q == QW)
        is_issuable = (req_idx < reqs.size() && q_in_req <= reqs[req_idx].fails) ? 1'b0 : 1'b1;
      else
        is_issuable = 1'($urandom_range(0, 1));
    end
  end

  function automatic treq_t rand_req(input logic [1:0] op, input int fails);
    treq_t r;
    r.op    = op;
    r.addr  = $urandom;
    r.data  = $urandom;
    r.tag   = $urandom;
    r.tid   = 8'($urandom);
    r.fails = fails;
    return r;
  endfunction

  // Expected event schedule derived from the handshake timing rules.
  task automatic build_schedule(input int k);
    int   qt, nq, last;
    cmd_t c;
    qt = k + 1;
    pop_at.delete();
    foreach (reqs[j]) begin
      pop_at.push_back(qt);
      nq = (reqs[j].fails > MR) ? MR + 1 : reqs[j].fails + 1;
      for (int i = 0; i < nq; i++) begin
        c = mk_cmd(qt + i * PER, qchar(reqs[j].op), reqs[j]);
        exp_cmd.push_back(c);
      end
      last = qt + (nq - 1) * PER;
      end_cyc = last + QW + 1;
      if (reqs[j].fails > MR) begin
        exp_drop.push_back(last + QW + 1);
        qt = last + QW + 2;
      end else begin
        c = mk_cmd(last + QW + 1, qchar(reqs[j].op) - 8'h20, reqs[j]);
        exp_cmd.push_back(c);
        exp_done.push_back(last + QW + 1);
        qt = last + QW + 1 + CD + 2;
      end
    end
  endtask

  // Push all planned requests back-to-back, checking req_ready, then compare logs.
  task automatic run_batch(input string name);
    int   k, idx, guard, popped, occ, target, n;
    logic pop_now, exp_rdy;
    cmd_t a, e;
    cmd_log.delete(); exp_cmd.delete();
    done_log.delete(); exp_done.delete();
    drop_log.delete(); exp_drop.delete();
    req_idx = 0; q_in_req = 0;
    ce_violations = 0;
    k = -1; idx = 0; guard = 0; end_cyc = 0;
    while (idx < reqs.size() && guard < 2000) begin
      @(negedge clk);
      guard++;
      req_valid = 1'b1;
      req_op    = reqs[idx].op;
      req_addr  = reqs[idx].addr;
      req_data  = reqs[idx].data;
      req_tag   = reqs[idx].tag;
      req_tid   = reqs[idx].tid;
      #1;
      if (k < 0) begin
        exp_rdy = 1'b1;
      end else begin
        popped = 0; pop_now = 1'b0;
        foreach (pop_at[j]) begin
          if (pop_at[j] <= cyc)     popped++;
          if (pop_at[j] == cyc + 1) pop_now = 1'b1;
        end
        occ = idx - popped;
        exp_rdy = (occ < DEPTH) || pop_now;
      end
      tests_run++;
      if (req_ready !== exp_rdy) begin
        failed++;
        $display("FAIL %s req_ready cyc=%0d got=%b exp=%b", name, cyc, req_ready, exp_rdy);
      end
      if (req_ready) begin
        @(posedge clk);
        #1;
        if (k < 0) begin
          k = cyc;
          build_schedule(k);
        end
        idx++;
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    tests_run++;
    if (idx != reqs.size()) begin
      failed++;
      $display("FAIL %s push_timeout accepted=%0d exp=%0d", name, idx, reqs.size());
      return;
    end
    target = end_cyc + CD + 4;
    guard = 0;
    while (cyc < target && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    tests_run++;
    if (cmd_log.size() != exp_cmd.size()) begin
      failed++;
      $display("FAIL %s cmd_count got=%0d exp=%0d", name, cmd_log.size(), exp_cmd.size());
    end
    n = (cmd_log.size() < exp_cmd.size()) ? cmd_log.size() : exp_cmd.size();
    for (int i = 0; i < n; i++) begin
      a = cmd_log[i];
      e = exp_cmd[i];
      tests_run++;
      if (a.cyc != e.cyc || a.a0 !== e.a0 || a.a1 !== e.a1 || a.a2 !== e.a2 ||
          a.a3 !== e.a3 || a.a4 !== e.a4) begin
        failed++;
        $display("FAIL %s cmd[%0d] got cyc=%0d a0=%h a1=%h a2=%h a3=%h a4=%h exp cyc=%0d a0=%h a1=%h a2=%h a3=%h a4=%h",
                 name, i, a.cyc, a.a0, a.a1, a.a2, a.a3, a.a4,
                 e.cyc, e.a0, e.a1, e.a2, e.a3, e.a4);
      end
    end
    tests_run++;
    if (done_log != exp_done) begin
      failed++;
      $display("FAIL %s issue_done got=%p exp=%p", name, done_log, exp_done);
    end
    tests_run++;
    if (drop_log != exp_drop) begin
      failed++;
      $display("FAIL %s drop_err got=%p exp=%p", name, drop_log, exp_drop);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      failed++;
      $display("FAIL %s busy_after got=%b exp=0", name, busy);
    end
    tests_run++;
    if (ce_violations != 0) begin
      failed++;
      $display("FAIL %s cmd_en_consecutive got=%0d exp=0", name, ce_violations);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0; req_op = '0; req_addr = '0; req_data = '0; req_tag = '0; req_tid = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({command_enable, issue_done, drop_err, busy, req_ready} !== 5'b00001) begin
      failed++;
      $display("FAIL reset_ctrl got ce=%b done=%b drop=%b busy=%b rdy=%b exp 0/0/0/0/1",
               command_enable, issue_done, drop_err, busy, req_ready);
    end
    tests_run++;
    if ({arg0, arg1, arg2, arg3, arg4} !== 112'd0) begin
      failed++;
      $display("FAIL reset_args got %h %h %h %h %h exp all zero", arg0, arg1, arg2, arg3, arg4);
    end
`ifdef NVMAIN_ISSUER_STATS_EN
    tests_run++;
    if ({stat_issued, stat_retries, stat_drops} !== 80'd0) begin
      failed++;
      $display("FAIL reset_stats got %0d %0d %0d exp 0", stat_issued, stat_retries, stat_drops);
    end
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_read();
    treq_t r;
    r = rand_req(2'd0, 0);
    r.addr = 32'h0000_1000;
    r.tag  = 32'd7;
    reqs.delete();
    reqs.push_back(r);
    run_batch("single_read");
    tests_run++;
    if (cmd_log.size() == 2 &&
        (cmd_log[0].a0 !== 8'h72 || cmd_log[1].a0 !== 8'h52 ||
         cmd_log[1].cyc - cmd_log[0].cyc != 4 || cmd_log[0].a3 !== 32'd7 ||
         cmd_log[1].a1 !== 32'h0000_1000)) begin
      failed++;
      $display("FAIL single_read_pair got a0=%h/%h gap=%0d exp 72/52 gap=4",
               cmd_log[0].a0, cmd_log[1].a0, cmd_log[1].cyc - cmd_log[0].cyc);
    end
  endtask

  task automatic test_retry_write();
`ifdef NVMAIN_ISSUER_STATS_EN
    logic [31:0] r0, i0;
    r0 = stat_retries;
    i0 = stat_issued;
`endif
    reqs.delete();
    reqs.push_back(rand_req(2'd1, 2));
    run_batch("retry_write");
`ifdef NVMAIN_ISSUER_STATS_EN
    tests_run++;
    if (stat_retries - r0 != 32'd2 || stat_issued - i0 != 32'd1) begin
      failed++;
      $display("FAIL retry_stats got retries+%0d issued+%0d exp +2 +1",
               stat_retries - r0, stat_issued - i0);
    end
`endif
  endtask

  task automatic test_drop();
    int nq, nu;
`ifdef NVMAIN_ISSUER_STATS_EN
    logic [15:0] d0;
    d0 = stat_drops;
`endif
    reqs.delete();
    reqs.push_back(rand_req(2'd3, 99));
    reqs.push_back(rand_req(2'($urandom_range(0, 2)), 0));
    run_batch("drop");
    nq = 0; nu = 0;
    foreach (cmd_log[i]) begin
      if (cmd_log[i].a0 == 8'h63) nq++;
      if (cmd_log[i].a0 == 8'h43) nu++;
    end
    tests_run++;
    if (nq != 3 || nu != 0 || drop_log.size() != 1 || done_log.size() != 1) begin
      failed++;
      $display("FAIL drop_counts got q=%0d C=%0d drops=%0d issues=%0d exp 3 0 1 1",
               nq, nu, drop_log.size(), done_log.size());
    end
`ifdef NVMAIN_ISSUER_STATS_EN
    tests_run++;
    if (stat_drops - d0 != 16'd1) begin
      failed++;
      $display("FAIL drop_stats got +%0d exp +1", stat_drops - d0);
    end
`endif
  endtask

  task automatic test_back_to_back();
    reqs.delete();
    for (int i = 0; i < 6; i++)
      reqs.push_back(rand_req(2'($urandom_range(0, 3)), $urandom_range(0, 1)));
    run_batch("back_to_back");
  endtask

  task automatic test_random_mix();
    reqs.delete();
    for (int i = 0; i < 8; i++)
      reqs.push_back(rand_req(2'($urandom_range(0, 3)), $urandom_range(0, 3)));
    run_batch("random_mix");
  endtask

  task automatic test_reset_mid_wait();
    int k, guard;
    cmd_log.delete(); done_log.delete(); drop_log.delete();
    reqs.delete();
    reqs.push_back(rand_req(2'd2, 0));
    req_idx = 0; q_in_req = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op = reqs[0].op; req_addr = reqs[0].addr; req_data = reqs[0].data;
    req_tag = reqs[0].tag; req_tid = reqs[0].tid;
    @(posedge clk);
    #1;
    k = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (cyc < k + 2 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({command_enable, busy, req_ready, drop_err, issue_done} !== 5'b00100) begin
      failed++;
      $display("FAIL reset_mid_wait_hold got ce=%b busy=%b rdy=%b drop=%b done=%b exp 0/0/1/0/0",
               command_enable, busy, req_ready, drop_err, issue_done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (command_enable !== 1'b0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL reset_mid_wait_after got ce=%b busy=%b exp 0/0", command_enable, busy);
    end
    repeat (20) @(negedge clk);
    tests_run++;
    if (cmd_log.size() != 1 || done_log.size() != 0 || drop_log.size() != 0) begin
      failed++;
      $display("FAIL reset_mid_wait_abandon got cmds=%0d issues=%0d drops=%0d exp 1 0 0",
               cmd_log.size(), done_log.size(), drop_log.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_retry_write();
    test_drop();
    test_back_to_back();
    test_random_mix();
    test_reset_mid_wait();
    test_single_read();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
